// File: rtl/phase_shift_gen_if.sv
// Bus bundle for phase_shift_gen: control/config inputs and waveform outputs.
// Optional macro PHASE_DIR_EN adds the dir input (phase direction select).
interface phase_shift_gen_if #(
    parameter int unsigned W = 8
);
    logic         en;
    logic         load;
    logic [W-1:0] period_in;
    logic [W-1:0] phase_in;
`ifdef PHASE_DIR_EN
    logic         dir;
`endif
    logic         encA;
    logic         encB;
    logic         sync;
    logic         busy;

    // Stimulus side: drives control/config, observes waveforms.
    modport master (
        output en, load, period_in, phase_in,
`ifdef PHASE_DIR_EN
        output dir,
`endif
        input  encA, encB, sync, busy
    );

    // Generator side.
    modport slave (
        input  en, load, period_in, phase_in,
`ifdef PHASE_DIR_EN
        input  dir,
`endif
        output encA, encB, sync, busy
    );
endinterface

// File: rtl/phase_shift_gen.sv
// Quadrature-style square-wave pair with programmable period and phase lag.
// Config values are double-buffered (shadow -> active) and only switch at a
// period boundary, so a running waveform is never truncated.
// Optional macro PHASE_DIR_EN: adds bus.dir, which swaps lead/lag roles.
module phase_shift_gen #(
    parameter int unsigned W = 8
) (
    input  logic              clk,
    input  logic              rst,
    phase_shift_gen_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] p_q, p_d;
    logic [W-1:0] ph_q, ph_d;
    logic [W-1:0] ps_q, ps_d;
    logic [W-1:0] phs_q, phs_d;
    logic         enc_a_q, enc_a_d;
    logic         enc_b_q, enc_b_d;
    logic         sync_q, sync_d;
`ifdef PHASE_DIR_EN
    logic         dir_q, dir_d;
`endif

    logic [W-1:0] src_p, src_ph, new_p, new_ph, half, pcnt;
    logic         lead, lag;

    // Next-state, counter, config copy and waveform decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        ph_d    = ph_q;
        enc_a_d = 1'b0;
        enc_b_d = 1'b0;
        sync_d  = 1'b0;
`ifdef PHASE_DIR_EN
        dir_d   = dir_q;
`endif
        // A load coinciding with a boundary copy must win, so bypass the shadow.
        src_p  = bus.load ? bus.period_in : ps_q;
        src_ph = bus.load ? bus.phase_in  : phs_q;
        ps_d   = src_p;
        phs_d  = src_ph;
        new_p  = (src_p < W'(2)) ? W'(2) : src_p;
        new_ph = (src_ph > (new_p - W'(1))) ? (new_p - W'(1)) : src_ph;

        half = p_q >> 1;
        // Lagged count; cnt + (P - PH) stays below P so it never overflows W.
        pcnt = (cnt_q >= ph_q) ? (cnt_q - ph_q) : (cnt_q + (p_q - ph_q));
        lead = (cnt_q < half);
        lag  = (pcnt < half);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.en) begin
                    state_d = RUN;
                    p_d     = new_p;
                    ph_d    = new_ph;
`ifdef PHASE_DIR_EN
                    dir_d   = bus.dir;
`endif
                end
            end
            RUN: begin
`ifdef PHASE_DIR_EN
                enc_a_d = dir_q ? lag  : lead;
                enc_b_d = dir_q ? lead : lag;
`else
                enc_a_d = lead;
                enc_b_d = lag;
`endif
                sync_d  = (cnt_q == '0);
                if (cnt_q == (p_q - W'(1))) begin
                    cnt_d = '0;
                    p_d   = new_p;
                    ph_d  = new_ph;
`ifdef PHASE_DIR_EN
                    dir_d = bus.dir;
`endif
                    if (!bus.en) begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset to defaults.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= W'(8);
            ph_q    <= W'(2);
            ps_q    <= W'(8);
            phs_q   <= W'(2);
            enc_a_q <= 1'b0;
            enc_b_q <= 1'b0;
            sync_q  <= 1'b0;
`ifdef PHASE_DIR_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            ph_q    <= ph_d;
            ps_q    <= ps_d;
            phs_q   <= phs_d;
            enc_a_q <= enc_a_d;
            enc_b_q <= enc_b_d;
            sync_q  <= sync_d;
`ifdef PHASE_DIR_EN
            dir_q   <= dir_d;
`endif
        end
    end

    assign bus.encA = enc_a_q;
    assign bus.encB = enc_b_q;
    assign bus.sync = sync_q;
    assign bus.busy = (state_q == RUN);
endmodule

// File: doc/phase_shift_gen.md
PHASE_SHIFT_GEN -- requirements
Module: phase_shift_gen

Interface
REQ-001 Parameter: W, 8, width of period/phase/counter datapath.
REQ-002 clk  input  1  rising-edge system clock, sole clock.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 en  input  1  level; 1 = generate waveforms, 0 = stop at end of current period.
REQ-005 load  input  1  one-cycle strobe; captures period_in/phase_in into shadow registers.
REQ-006 period_in  input  W  full waveform period in clk cycles.
REQ-007 phase_in  input  W  encB lag behind encA in clk cycles.
REQ-008 encA  output  1  reference square wave, registered.
REQ-009 encB  output  1  phase-shifted square wave, registered.
REQ-010 sync  output  1  one-cycle pulse, registered, marking each period start.
REQ-011 busy  output  1  1 while state = RUN.

Function
REQ-012 States: IDLE, RUN; IDLE->RUN on en=1; RUN->IDLE when en=0 and cnt = P-1.
REQ-013 Shadow regs (Ps, PHs) written on load; active regs (P, PH) copied from shadow on IDLE->RUN and at every cnt = P-1 in RUN, never mid-period.
REQ-014 P = max(Ps, 2); PH = min(PHs, P-1); all arithmetic W bits, no overflow beyond W.
REQ-015 cnt counts 0..P-1 in RUN, wraps to 0 after P-1; held 0 in IDLE.
REQ-016 H = P >> 1; encA <= (cnt < H) registered, so encA rises one clk after cnt = 0.
REQ-017 pcnt = cnt - PH if cnt >= PH, else cnt + P - PH; encB <= (pcnt < H) registered.
REQ-018 sync <= 1 for exactly one cycle when cnt = 0 in RUN, else 0.
REQ-019 In IDLE, encA, encB, sync driven 0 from the cycle after entry.
REQ-020 load while RUN: new values take effect at next period boundary; load on same cycle as boundary copy: the new load values win.
REQ-021 en dropping mid-period: current period completes, no truncated pulse; en reasserted before cnt = P-1: stays RUN, no gap.
REQ-022 PH = 0: encB identical to encA; odd P: high time H, low time P-H.

Reset
REQ-023 rst=1 at any clk edge: state IDLE, cnt 0, encA 0, encB 0, sync 0, busy 0, Ps = 8, PHs = 2, P = 8, PH = 2.
REQ-024 rst mid-RUN takes effect immediately at that edge, overriding en, load and boundary copy.

Configuration
REQ-025 Macro PHASE_DIR_EN defined: extra input dir (1 bit, after phase_in); dir=1 swaps roles so encA lags encB by PH; dir sampled only at period boundary like P/PH.
REQ-026 PHASE_DIR_EN undefined: no dir port, encA always leads encB.

Verification
REQ-027 Reset then en=1, defaults P=8, PH=2 -> encA high 4 clk / low 4 clk, encB same shape rising exactly 2 clk after encA, sync every 8 clk.
REQ-028 load period_in=10, phase_in=3 mid-period -> current period still 8 clk; next period encA 5 high/5 low, encB lag 3.
REQ-029 load period_in=1, phase_in=9 -> P=2, PH=1: encA toggles every clk, encB = encA inverted.
REQ-030 en=0 at cnt=3 of P=8 -> waveform runs to cnt=7, then encA=encB=0, busy=0 next cycle.
REQ-031 rst=1 at cnt=5 in RUN -> next cycle all outputs 0, busy 0; after rst release with en=1, restarts at cnt=0 with P=8, PH=2.
REQ-032 PHASE_DIR_EN defined, dir=1, P=8, PH=2 -> encB rises 2 clk before encA.
